// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Target-side data memory for the pipelined core. It services load and store
// requests from a word-organised synchronous RAM. Every access goes through
// IDLE -> READ (-> WRITE for stores). Sub-word stores are therefore a
// read-modify-write of the fetched word.
//
// Parameters:
//   BASE_ADDR   byte address of RAM word 0
//   DEPTH_WORDS number of 32-bit RAM words (power of two)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   addr        byte address of the access
//   write_data  store data, right-aligned
//   memwrite    store request (wins over memread when both are set)
//   memread     load request
//   sign_mask   [3] sign-extend load, [2:0] 001 byte / 011 half / 111 word
//   read_data   formatted load result, held until the next load completes
//   clk_stall   access in flight (READ or WRITE); the core holds its request
//   access_err  sticky flag for misaligned or out-of-range accesses
//   led         (DATA_MEM_MMIO_LED_EN only) register written by a store to
//               byte address 32'h0000_2000
//
// Optional feature macro: DATA_MEM_MMIO_LED_EN (memory-mapped LED register).
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic        access_err
`ifdef DATA_MEM_MMIO_LED_EN
  ,
  output logic [7:0]  led
`endif
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33 bits so BASE_ADDR + span can never wrap in the range compare.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [2:0]  SZ_BYTE    = 3'b001;
  localparam logic [2:0]  SZ_HALF    = 3'b011;
`ifdef DATA_MEM_MMIO_LED_EN
  localparam logic [31:0] LED_ADDR   = 32'h0000_2000;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Shift the selected lane down to bit 0 and zero- or sign-fill above it.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [3:0]  mask);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (mask[2:0])
      SZ_BYTE: res = {{24{mask[3] & b[7]}}, b};
      SZ_HALF: res = {{16{mask[3] & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the right-aligned store data onto the selected lanes of a word.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          2'd3:    res[31:24] = data[7:0];
          default: res        = word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0]  = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  state_t        state_r, state_s;
  logic          req_s, accept_s, load_fin_s, we_s;
  logic [31:0]   align_addr_s, offset_s, merged_s, load_fmt_s;
  logic          misalign_s, oob_s, led_hit_s;

  logic [1:0]    lane_r;
  logic [31:0]   wdata_r;
  logic [3:0]    mask_r;
  logic          store_r, oob_r, led_hit_r, load_done_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   ram_q_r;
  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [31:0]   read_data_r;
  logic          clk_stall_r, access_err_r;
`ifdef DATA_MEM_MMIO_LED_EN
  logic [7:0]    led_r;
`endif

  assign req_s = memread | memwrite;

  // Request decode: align the address, flag misalignment and range errors.
  always_comb begin
    align_addr_s = addr;
    misalign_s   = 1'b0;
    case (sign_mask[2:0])
      SZ_BYTE: begin
        align_addr_s = addr;
        misalign_s   = 1'b0;
      end
      SZ_HALF: begin
        align_addr_s = {addr[31:1], 1'b0};
        misalign_s   = addr[0];
      end
      default: begin
        align_addr_s = {addr[31:2], 2'b00};
        misalign_s   = |addr[1:0];
      end
    endcase
    offset_s = align_addr_s - BASE_ADDR;
`ifdef DATA_MEM_MMIO_LED_EN
    led_hit_s = (addr == LED_ADDR);
`else
    led_hit_s = 1'b0;
`endif
    if (led_hit_s) begin
      oob_s = 1'b0;
    end else if (align_addr_s < BASE_ADDR) begin
      oob_s = 1'b1;
    end else begin
      oob_s = ({1'b0, offset_s} >= SPAN_BYTES);
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s  = READ;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      READ: begin
        if (store_r) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
    load_fin_s = (state_r == READ) & ~store_r;
    // Out-of-range and LED stores never touch the RAM.
    we_s       = (state_r == WRITE) & ~oob_r & ~led_hit_r;
  end

  // Load result selection from the fetched word, LED register or zero.
  always_comb begin
    load_fmt_s = 32'd0;
    if (oob_r) begin
      load_fmt_s = 32'd0;
    end
`ifdef DATA_MEM_MMIO_LED_EN
    else if (led_hit_r) begin
      load_fmt_s = {24'd0, led_r};
    end
`endif
    else begin
      load_fmt_s = format_load(ram_q_r, lane_r, mask_r);
    end
  end

  assign merged_s = merge_store(ram_q_r, wdata_r, lane_r, mask_r[2:0]);

  // FSM state, request capture, status flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      clk_stall_r  <= 1'b0;
      access_err_r <= 1'b0;
      read_data_r  <= 32'd0;
      load_done_r  <= 1'b0;
      lane_r       <= 2'd0;
      wdata_r      <= 32'd0;
      mask_r       <= 4'd0;
      store_r      <= 1'b0;
      oob_r        <= 1'b0;
      led_hit_r    <= 1'b0;
      idx_r        <= '0;
`ifdef DATA_MEM_MMIO_LED_EN
      led_r        <= 8'd0;
`endif
    end else begin
      state_r     <= state_s;
      clk_stall_r <= (state_s != IDLE);
      load_done_r <= load_fin_s;
      if (accept_s) begin
        lane_r       <= align_addr_s[1:0];
        wdata_r      <= write_data;
        mask_r       <= sign_mask;
        store_r      <= memwrite;
        oob_r        <= oob_s;
        led_hit_r    <= led_hit_s;
        idx_r        <= AW'(offset_s >> 2);
        access_err_r <= access_err_r | misalign_s | oob_s;
      end
      // The RAM word was captured at the READ->IDLE edge; format it one
      // edge later.
      if (load_done_r) begin
        read_data_r <= load_fmt_s;
      end
`ifdef DATA_MEM_MMIO_LED_EN
      if ((state_r == WRITE) && led_hit_r) begin
        led_r <= wdata_r[7:0];
      end
`endif
    end
  end

  // Synchronous RAM: registered read in READ, write of the merged word in WRITE.
  always_ff @(posedge clk) begin
    if (state_r == READ) begin
      ram_q_r <= mem_r[idx_r];
    end
    if (we_s) begin
      mem_r[idx_r] <= merged_s;
    end
  end

  assign read_data  = read_data_r;
  assign clk_stall  = clk_stall_r;
  assign access_err = access_err_r;
`ifdef DATA_MEM_MMIO_LED_EN
  assign led        = led_r;
`endif

endmodule
